// File: rtl/keypoint_collector.sv
// Keypoint collector: accepts one row of per-channel candidate bitmaps, applies border
// rejection, then serially compacts surviving bits into {row, col} writes per channel SRAM.
module keypoint_collector #(
    parameter int NUM_CH = 2,
    parameter int COLS   = 640,
    parameter int ROWS   = 480,
    parameter int ROW_W  = 9,
    parameter int COL_W  = 10,
    parameter int ADDR_W = 11,
    parameter int BORDER = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            frame_start,
    input  logic                            row_valid,
    output logic                            row_ready,
    input  logic [ROW_W-1:0]                row_idx,
    input  logic [NUM_CH*COLS-1:0]          cand_mask,
    output logic [NUM_CH-1:0]               kp_we,
    output logic [NUM_CH*ADDR_W-1:0]        kp_addr,
    output logic [NUM_CH*(ROW_W+COL_W)-1:0] kp_din,
    output logic [NUM_CH*(ADDR_W+1)-1:0]    kp_count,
    output logic [NUM_CH-1:0]               overflow,
    output logic                            busy,
    output logic                            frame_done,
    output logic [1:0]                      dbg_state_o
);

    localparam int DW = ROW_W + COL_W;
    localparam int CW = ADDR_W + 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCEPT = 2'd1;
    localparam logic [1:0] S_SCAN   = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [COLS-1:0] MASK_ONE = COLS'(1);

    // Handshake: a row transfers on a rising edge where row_valid && row_ready.
    // row_ready is high only in ACCEPT, so row_valid is ignored in every other state.

    logic [1:0]                         state_q, state_d;
    logic [ROW_W-1:0]                   row_q, row_d;
    logic [NUM_CH-1:0][COLS-1:0]        mask_q, mask_d;
    logic [NUM_CH-1:0][CW-1:0]          count_q, count_d;
    logic [NUM_CH-1:0]                  ovf_q, ovf_d;
    logic [NUM_CH-1:0]                  we_q, we_d;
    logic [NUM_CH-1:0][ADDR_W-1:0]      addr_q, addr_d;
    logic [NUM_CH-1:0][DW-1:0]          din_q, din_d;

    logic [COLS-1:0]                    col_keep;
    logic                               row_in_range;
    logic [NUM_CH-1:0]                  hit;
    logic [NUM_CH-1:0][COL_W-1:0]       pos;

    for (genvar j = 0; j < COLS; j++) begin : g_keep
        assign col_keep[j] = (j >= BORDER) && (j < COLS - BORDER);
    end

    assign row_in_range = (row_idx >= ROW_W'(BORDER)) && (row_idx < ROW_W'(ROWS - BORDER));

    // Lowest set bit per channel; the descending loop lets the lowest index win.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            hit[c] = 1'b0;
            pos[c] = '0;
            for (int j = COLS - 1; j >= 0; j--) begin
                if (mask_q[c][j]) begin
                    hit[c] = 1'b1;
                    pos[c] = COL_W'(j);
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        mask_d  = mask_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        we_d    = '0;
        addr_d  = addr_q;
        din_d   = din_q;
        case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    count_d = '0;
                    ovf_d   = '0;
                    mask_d  = '0;
                    state_d = S_ACCEPT;
                end
            end
            S_ACCEPT: begin
                if (row_valid) begin
                    row_d = row_idx;
                    for (int c = 0; c < NUM_CH; c++) begin
                        mask_d[c] = row_in_range ? (cand_mask[c*COLS +: COLS] & col_keep) : '0;
                    end
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                if (mask_q == '0) begin
                    state_d = (row_q == ROW_W'(ROWS - 1)) ? S_DONE : S_ACCEPT;
                end else begin
                    for (int c = 0; c < NUM_CH; c++) begin
                        if (hit[c]) begin
                            // Clearing the lowest set bit also consumes candidates dropped when full.
                            mask_d[c] = mask_q[c] & (mask_q[c] - MASK_ONE);
                            if (count_q[c][ADDR_W]) begin
                                ovf_d[c] = 1'b1;
                            end else begin
                                we_d[c]    = 1'b1;
                                addr_d[c]  = count_q[c][ADDR_W-1:0];
                                din_d[c]   = {row_q, pos[c]};
                                count_d[c] = count_q[c] + CNT_ONE;
                            end
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            mask_q  <= '0;
            count_q <= '0;
            ovf_q   <= '0;
            we_q    <= '0;
            addr_q  <= '0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            mask_q  <= mask_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
        end
    end

    assign row_ready   = (state_q == S_ACCEPT);
    assign busy        = (state_q != S_IDLE);
    assign frame_done  = (state_q == S_DONE);
    assign dbg_state_o = state_q;
    assign kp_we       = we_q;
    assign kp_addr     = addr_q;
    assign kp_din      = din_q;
    assign kp_count    = count_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_keypoint_collector.sv
// Bench for keypoint_collector: table vectors, hand corner sequences and random frames,
// all checked against a column-scan reference model with per-channel expected write queues.
module tb_keypoint_collector;

    localparam int NUM_CH = 2;
    localparam int COLS   = 640;
    localparam int ROWS   = 480;
    localparam int ROW_W  = 9;
    localparam int COL_W  = 10;
    localparam int ADDR_W = 2;
    localparam int BORDER = 1;
    localparam int DW     = ROW_W + COL_W;
    localparam int CW     = ADDR_W + 1;
    localparam int EW     = ADDR_W + DW;
    localparam int CAP    = 1 << ADDR_W;

    logic                            clk;
    logic                            rst;
    logic                            frame_start;
    logic                            row_valid;
    logic                            row_ready;
    logic [ROW_W-1:0]                row_idx;
    logic [NUM_CH*COLS-1:0]          cand_mask;
    logic [NUM_CH-1:0]               kp_we;
    logic [NUM_CH*ADDR_W-1:0]        kp_addr;
    logic [NUM_CH*DW-1:0]            kp_din;
    logic [NUM_CH*CW-1:0]            kp_count;
    logic [NUM_CH-1:0]               overflow;
    logic                            busy;
    logic                            frame_done;
    logic [1:0]                      dbg_state;

    keypoint_collector #(
        .NUM_CH(NUM_CH), .COLS(COLS), .ROWS(ROWS), .ROW_W(ROW_W),
        .COL_W(COL_W), .ADDR_W(ADDR_W), .BORDER(BORDER)
    ) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .row_valid(row_valid),
        .row_ready(row_ready), .row_idx(row_idx), .cand_mask(cand_mask),
        .kp_we(kp_we), .kp_addr(kp_addr), .kp_din(kp_din), .kp_count(kp_count),
        .overflow(overflow), .busy(busy), .frame_done(frame_done), .dbg_state_o(dbg_state)
    );

    // ---- clock / reset ----
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

    // ---- scoreboard ----
    int n_cmp = 0;
    int n_bad = 0;
    int done_seen = 0;
    int exp_done = 0;
    int wr0, wr1;
    int mcnt[2];
    bit movf[2];
    int m_scan;
    logic [EW-1:0] exp_q0[$];
    logic [EW-1:0] exp_q1[$];

    typedef struct {
        int row;
        int p0a, p0b, p0c;
        int p1a, p1b, p1c;
        int scan;
        int w0;
        int w1;
    } vec_t;

    vec_t vt[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // One clock step; outputs are sampled on the falling edge and writes scored here.
    task automatic tick();
        logic [EW-1:0] a;
        logic [EW-1:0] e;
        @(negedge clk);
        if (frame_done) done_seen++;
        if (!rst) begin
            if (kp_we[0]) begin
                wr0++;
                a = {kp_addr[0 +: ADDR_W], kp_din[0 +: DW]};
                check("write_expected_ch0", exp_q0.size() != 0, 1);
                if (exp_q0.size() != 0) begin
                    e = exp_q0.pop_front();
                    check("write_ch0", a, e);
                end
            end
            if (kp_we[1]) begin
                wr1++;
                a = {kp_addr[ADDR_W +: ADDR_W], kp_din[DW +: DW]};
                check("write_expected_ch1", exp_q1.size() != 0, 1);
                if (exp_q1.size() != 0) begin
                    e = exp_q1.pop_front();
                    check("write_ch1", a, e);
                end
            end
        end
    endtask

    // Reference: scan the in-border columns left to right, storing until the SRAM is full.
    task automatic model_row(input int row, input logic [COLS-1:0] m0, input logic [COLS-1:0] m1);
        int hits;
        logic [EW-1:0] e;
        logic bitv;
        m_scan = 1;
        if (row < BORDER || row >= ROWS - BORDER) return;
        for (int c = 0; c < 2; c++) begin
            hits = 0;
            for (int j = BORDER; j < COLS - BORDER; j++) begin
                bitv = (c == 0) ? m0[j] : m1[j];
                if (bitv) begin
                    hits++;
                    if (mcnt[c] < CAP) begin
                        e = {ADDR_W'(mcnt[c]), ROW_W'(row), COL_W'(j)};
                        if (c == 0) exp_q0.push_back(e);
                        else        exp_q1.push_back(e);
                        mcnt[c]++;
                    end else begin
                        movf[c] = 1'b1;
                    end
                end
            end
            if (hits + 1 > m_scan) m_scan = hits + 1;
        end
    endtask

    function automatic logic [COLS-1:0] bits3(input int a, input int b, input int c);
        logic [COLS-1:0] m;
        m = '0;
        if (a >= 0) m[a] = 1'b1;
        if (b >= 0) m[b] = 1'b1;
        if (c >= 0) m[c] = 1'b1;
        return m;
    endfunction

    function automatic logic [COLS-1:0] rand_mask();
        logic [COLS-1:0] m;
        int k;
        m = '0;
        k = $urandom_range(0, 3);
        for (int i = 0; i < k; i++) m[$urandom_range(0, COLS - 1)] = 1'b1;
        return m;
    endfunction

    // ---- driver tasks ----
    task automatic start_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        mcnt[0] = 0; mcnt[1] = 0;
        movf[0] = 1'b0; movf[1] = 1'b0;
    endtask

    task automatic send_row(input int row, input logic [COLS-1:0] m0, input logic [COLS-1:0] m1,
                            input bit fs_poke, output int scan);
        int n;
        n = 0;
        row_valid = 1'b1;
        row_idx   = ROW_W'(row);
        cand_mask = {m1, m0};
        while (!row_ready && n < 1000) begin
            tick();
            n++;
        end
        check("row_accept_in_time", n < 1000, 1);
        tick();
        row_valid = 1'b0;
        model_row(row, m0, m1);
        scan = 0;
        while (!row_ready && !frame_done && scan < 3000) begin
            if (fs_poke) frame_start = (scan == 0);
            scan++;
            tick();
        end
        frame_start = 1'b0;
        check("scan_cycles", scan, m_scan);
    endtask

    task automatic end_frame(input logic [COLS-1:0] m0, input logic [COLS-1:0] m1);
        int sc;
        send_row(ROWS - 1, m0, m1, 1'b0, sc);
        exp_done++;
        check("last_row_scan", sc, 1);
        check("frame_done_pulse", frame_done, 1);
        tick();
        check("frame_done_single", frame_done, 0);
        check("idle_after_done", busy, 0);
    endtask

    task automatic check_counts();
        check("kp_count_ch0", kp_count[0 +: CW], mcnt[0]);
        check("kp_count_ch1", kp_count[CW +: CW], mcnt[1]);
        check("overflow", overflow, {movf[1], movf[0]});
        check("pending_ch0", exp_q0.size(), 0);
        check("pending_ch1", exp_q1.size(), 0);
    endtask

    // ---- test sequence ----
    initial begin
        int sc;
        int done_before;
        int nrows;
        logic [COLS-1:0] ones;
        logic [COLS-1:0] ma;
        logic [COLS-1:0] mb;

        ones = '1;
        wr0 = 0; wr1 = 0;
        mcnt[0] = 0; mcnt[1] = 0;
        movf[0] = 1'b0; movf[1] = 1'b0;
        rst = 1'b1;
        frame_start = 1'b0;
        row_valid = 1'b0;
        row_idx = '0;
        cand_mask = '0;
        tick();
        tick();
        check("rst_row_ready", row_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_kp_we", kp_we, 0);
        check("rst_kp_count", kp_count, 0);
        check("rst_overflow", overflow, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_kp_addr", kp_addr, 0);
        check("rst_kp_din", kp_din, 0);
        rst = 1'b0;
        tick();

        // Table: one row per fresh frame.
        vt[0] = '{5,   3, 100, 639,   0,   2,  -1, 3, 2, 1};
        vt[1] = '{0,   1,   2,   3,   5,   6,   7, 1, 0, 0};
        vt[2] = '{478, 1, 638,  -1, 639,  -1,  -1, 3, 2, 0};
        vt[3] = '{10, -1,  -1,  -1,   1, 200, 638, 4, 0, 3};
        vt[4] = '{100, 0, 639,  -1,  -1,  -1,  -1, 1, 0, 0};
        vt[5] = '{1,  50,  51,  52,  52,  -1,  -1, 4, 3, 1};
        for (int i = 0; i < 6; i++) begin
            start_frame();
            wr0 = 0; wr1 = 0;
            send_row(vt[i].row, bits3(vt[i].p0a, vt[i].p0b, vt[i].p0c),
                     bits3(vt[i].p1a, vt[i].p1b, vt[i].p1c), 1'b0, sc);
            check("vec_scan", sc, vt[i].scan);
            check("vec_writes_ch0", wr0, vt[i].w0);
            check("vec_writes_ch1", wr1, vt[i].w1);
            check("vec_ready_back", row_ready, 1);
            end_frame('0, '0);
            check_counts();
        end

        // Border rows with all-ones masks write nothing.
        start_frame();
        wr0 = 0; wr1 = 0;
        send_row(0, ones, ones, 1'b0, sc);
        end_frame(ones, ones);
        check("border_rows_writes", wr0 + wr1, 0);
        check_counts();

        // Saturation: six candidates into a four-entry SRAM.
        start_frame();
        wr0 = 0; wr1 = 0;
        ma = bits3(2, 4, 6) | bits3(8, 10, 12);
        send_row(10, ma, '0, 1'b0, sc);
        check("sat_scan", sc, 7);
        check("sat_writes_ch0", wr0, 4);
        check("sat_writes_ch1", wr1, 0);
        end_frame('0, '0);
        check("sat_count_ch0", kp_count[0 +: CW], 4);
        check("sat_overflow", overflow, 2'b01);
        check_counts();

        // row_valid held with a changing payload while SCAN runs.
        start_frame();
        row_valid = 1'b1;
        row_idx = ROW_W'(20);
        cand_mask = {{COLS{1'b0}}, bits3(7, 9, -1)};
        tick();
        model_row(20, bits3(7, 9, -1), '0);
        row_idx = ROW_W'(21);
        cand_mask = {{COLS{1'b0}}, bits3(300, -1, -1)};
        tick();
        check("hold_ready_scan1", row_ready, 0);
        row_idx = ROW_W'(22);
        cand_mask = {bits3(400, 401, -1), bits3(5, -1, -1)};
        tick();
        check("hold_ready_scan2", row_ready, 0);
        tick();
        check("hold_ready_back", row_ready, 1);
        tick();
        row_valid = 1'b0;
        model_row(22, bits3(5, -1, -1), bits3(400, 401, -1));
        sc = 0;
        while (!row_ready && sc < 3000) begin
            sc++;
            tick();
        end
        check("hold_second_scan", sc, 3);
        end_frame('0, '0);
        check_counts();

        // Asynchronous reset in the middle of a row.
        start_frame();
        row_valid = 1'b1;
        row_idx = ROW_W'(10);
        cand_mask = {{COLS{1'b0}}, bits3(10, 20, 30) | bits3(40, 50, -1)};
        tick();
        row_valid = 1'b0;
        exp_q0.push_back({ADDR_W'(0), ROW_W'(10), COL_W'(10)});
        exp_q0.push_back({ADDR_W'(1), ROW_W'(10), COL_W'(20)});
        tick();
        tick();
        done_before = done_seen;
        #2;
        rst = 1'b1;
        #1;
        check("arst_kp_we", kp_we, 0);
        check("arst_busy", busy, 0);
        check("arst_row_ready", row_ready, 0);
        check("arst_kp_count", kp_count, 0);
        check("arst_kp_addr", kp_addr, 0);
        check("arst_kp_din", kp_din, 0);
        check("arst_overflow", overflow, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("arst_no_frame_done", done_seen, done_before);
        check("arst_writes_seen", exp_q0.size(), 0);
        start_frame();
        send_row(15, bits3(33, -1, -1), bits3(34, -1, -1), 1'b0, sc);
        end_frame('0, '0);
        check_counts();

        // frame_start while busy, and row_valid offered in IDLE.
        row_valid = 1'b1;
        row_idx = ROW_W'(50);
        cand_mask = {bits3(60, -1, -1), bits3(61, -1, -1)};
        tick();
        tick();
        check("idle_no_ready", row_ready, 0);
        check("idle_not_busy", busy, 0);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        mcnt[0] = 0; mcnt[1] = 0;
        movf[0] = 1'b0; movf[1] = 1'b0;
        send_row(50, bits3(61, -1, -1), bits3(60, -1, -1), 1'b0, sc);
        send_row(40, bits3(1, 2, -1), bits3(3, -1, -1), 1'b1, sc);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("busy_fs_state", row_ready, 1);
        send_row(41, bits3(5, -1, -1), '0, 1'b0, sc);
        end_frame('0, '0);
        check_counts();

        // Random frames.
        for (int f = 0; f < 25; f++) begin
            start_frame();
            nrows = $urandom_range(1, 4);
            for (int r = 0; r < nrows; r++) begin
                ma = rand_mask();
                mb = rand_mask();
                send_row($urandom_range(0, ROWS - 2), ma, mb, 1'b0, sc);
            end
            end_frame(rand_mask(), rand_mask());
            check_counts();
        end

        tick();
        check("frame_done_total", done_seen, exp_done);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
